// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with WB write-through bypass, plus a per-register
// pending-write scoreboard that holds ID while a source still has a write in flight.
module wb_regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr_ID_I,
  input  logic [4:0]      rs2_addr_ID_I,
  input  logic            rs1_use_ID_I,
  input  logic            rs2_use_ID_I,
  output logic [XLEN-1:0] rs1_data_ID_O,
  output logic [XLEN-1:0] rs2_data_ID_O,
  input  logic            issue_valid_ID_I,
  input  logic [4:0]      issue_rd_ID_I,
  input  logic            issue_we_ID_I,
  input  logic            cancel_valid_I,
  input  logic [4:0]      cancel_rd_I,
  input  logic            RegWrite_WB_I,
  input  logic [4:0]      Wr_addr_WB_I,
  input  logic [XLEN-1:0] Wr_data_WB_I,
  output logic            stall_ID_O
);

  localparam int DW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  regs_r    [1:31];
  logic [CNT_W-1:0] cnt_r     [1:31];
  logic [CNT_W-1:0] cnt_nxt_s [1:31];
  logic [CNT_W-1:0] rs1_cnt_s;
  logic [CNT_W-1:0] rs2_cnt_s;
  logic [CNT_W-1:0] rd_cnt_s;
  logic             rs1_busy_s;
  logic             rs2_busy_s;
  logic             rd_full_s;
  logic             stall_s;
  logic             issue_fire_s;

  // Same-cycle decrements (WB retire and/or cancel) aimed at register r: 0..2.
  function automatic logic [1:0] dec_cnt_f(
    input logic [4:0] r,
    input logic       wb_en,
    input logic [4:0] wb_addr,
    input logic       cancel_en,
    input logic [4:0] cancel_addr
  );
    dec_cnt_f = {1'b0, (wb_en && (wb_addr == r))} +
                {1'b0, (cancel_en && (cancel_addr == r))};
  endfunction

  // Counter lookup for both sources and the issuing destination; x0 has no counter.
  always_comb begin
    rs1_cnt_s = {CNT_W{1'b0}};
    rs2_cnt_s = {CNT_W{1'b0}};
    rd_cnt_s  = {CNT_W{1'b0}};
    if (rs1_addr_ID_I != 5'd0) rs1_cnt_s = cnt_r[rs1_addr_ID_I];
    else                       rs1_cnt_s = {CNT_W{1'b0}};
    if (rs2_addr_ID_I != 5'd0) rs2_cnt_s = cnt_r[rs2_addr_ID_I];
    else                       rs2_cnt_s = {CNT_W{1'b0}};
    if (issue_rd_ID_I != 5'd0) rd_cnt_s  = cnt_r[issue_rd_ID_I];
    else                       rd_cnt_s  = {CNT_W{1'b0}};
  end

  // A source is busy only if writes remain after this cycle's retire/cancel.
  assign rs1_busy_s = rs1_use_ID_I && (rs1_addr_ID_I != 5'd0) &&
                      (DW'(rs1_cnt_s) > DW'(dec_cnt_f(rs1_addr_ID_I, RegWrite_WB_I,
                                                      Wr_addr_WB_I, cancel_valid_I, cancel_rd_I)));
  assign rs2_busy_s = rs2_use_ID_I && (rs2_addr_ID_I != 5'd0) &&
                      (DW'(rs2_cnt_s) > DW'(dec_cnt_f(rs2_addr_ID_I, RegWrite_WB_I,
                                                      Wr_addr_WB_I, cancel_valid_I, cancel_rd_I)));
  assign rd_full_s  = issue_we_ID_I && (issue_rd_ID_I != 5'd0) && (rd_cnt_s == CNT_MAX) &&
                      (dec_cnt_f(issue_rd_ID_I, RegWrite_WB_I, Wr_addr_WB_I,
                                 cancel_valid_I, cancel_rd_I) == 2'd0);

  assign stall_s      = issue_valid_ID_I && (rs1_busy_s || rs2_busy_s || rd_full_s);
  assign issue_fire_s = issue_valid_ID_I && !stall_s && issue_we_ID_I && (issue_rd_ID_I != 5'd0);
  assign stall_ID_O   = stall_s;

  // Net counter update per register; an unmatched decrement saturates at zero.
  always_comb begin
    logic [DW-1:0] up_v;
    logic [DW-1:0] dn_v;
    up_v = {DW{1'b0}};
    dn_v = {DW{1'b0}};
    for (int r = 1; r < 32; r++) begin
      up_v = DW'(cnt_r[r]) + DW'(issue_fire_s && (issue_rd_ID_I == 5'(r)));
      dn_v = DW'(dec_cnt_f(5'(r), RegWrite_WB_I, Wr_addr_WB_I, cancel_valid_I, cancel_rd_I));
      if (up_v >= dn_v) cnt_nxt_s[r] = CNT_W'(up_v - dn_v);
      else              cnt_nxt_s[r] = {CNT_W{1'b0}};
    end
  end

  // Pending-write counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) cnt_r[r] <= {CNT_W{1'b0}};
    end else begin
      for (int r = 1; r < 32; r++) cnt_r[r] <= cnt_nxt_s[r];
    end
  end

  // Architectural register array, written from WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) regs_r[r] <= {XLEN{1'b0}};
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (RegWrite_WB_I && (Wr_addr_WB_I == 5'(r))) regs_r[r] <= Wr_data_WB_I;
      end
    end
  end

  // Read ports: x0 is zero, a same-cycle WB write to the address is forwarded.
  always_comb begin
    rs1_data_ID_O = {XLEN{1'b0}};
    rs2_data_ID_O = {XLEN{1'b0}};
    if (rs1_addr_ID_I == 5'd0)                                   rs1_data_ID_O = {XLEN{1'b0}};
    else if (RegWrite_WB_I && (Wr_addr_WB_I == rs1_addr_ID_I))   rs1_data_ID_O = Wr_data_WB_I;
    else                                                         rs1_data_ID_O = regs_r[rs1_addr_ID_I];
    if (rs2_addr_ID_I == 5'd0)                                   rs2_data_ID_O = {XLEN{1'b0}};
    else if (RegWrite_WB_I && (Wr_addr_WB_I == rs2_addr_ID_I))   rs2_data_ID_O = Wr_data_WB_I;
    else                                                         rs2_data_ID_O = regs_r[rs2_addr_ID_I];
  end

endmodule
